pl_stage_hs: RTL and testbench
==============================

// Module: pl_stage_hs
// PURPOSE
//  Generic pipeline-stage register with valid/ready handshake, flush and optional 2-entry skid buffer.
//  Replaces the fixed decode|execute register and is reused at every stage boundary (F|D, D|E, E|M, M|W).
//  Payload is split into CTRL (zeroed on flush/bubble so downstream sees inert control) and DATA (not cleared).
//  Stall is expressed as back-pressure (out_ready=0), not a separate enable.
// PARAMETERS
//  DATA_W   204  width of datapath payload (operands, imm, PC, instr, PC+4)
//  CTRL_W   12   width of control payload (result_src, alu_control, memwrite, alu_src, regwrite, branch, jalr, jump)
//  SKID_EN  1    1: registered in_ready via 2-entry skid; 0: single register, combinational in_ready
// PORTS
//  clk        in   1       rising-edge clock; one clock domain
//  rst        in   1       synchronous, active-high reset
//  flush      in   1       kill all held entries (branch/jump redirect)
//  in_valid   in   1       upstream has an entry
//  in_ready   out  1       stage can accept an entry this cycle
//  in_ctrl    in   CTRL_W  control payload
//  in_data    in   DATA_W  datapath payload
//  out_valid  out  1       head entry valid
//  out_ready  in   1       downstream accepts head entry
//  out_ctrl   out  CTRL_W  head control; 0 whenever out_valid=0
//  out_data   out  DATA_W  head datapath payload
//  occupancy  out  2       entries held (0..2; max 1 when SKID_EN=0)
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; all state updates on posedge clk.
//  - Reset (rst=1 at edge): state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid cleared, occupancy=0;
//    in_ready=1 from the first cycle after reset; handshakes in the reset cycle are discarded.
//  - Latency 1 cycle in->out; throughput 1 entry/cycle while out_ready held high.
//  - States (SKID_EN=1): EMPTY(0) / ONE(main full) / TWO(main+skid full); in_ready = (state!=TWO), registered.
//    EMPTY: in_fire -> ONE, main<=in.
//    ONE:   in_fire&out_fire -> ONE, main<=in;  out_fire only -> EMPTY;  in_fire only -> TWO, skid<=in; else hold.
//    TWO:   out_fire -> ONE, main<=skid, skid cleared; else hold (no in_fire possible).
//  - SKID_EN=0: state EMPTY/ONE only; in_ready = out_ready | ~out_valid (combinational).
//  - Ordering strictly FIFO; payload of a held entry never changes while out_valid=1 & out_ready=0.
//  - Bubble rule: any transition to EMPTY, and reset, writes out_ctrl=0; out_data holds last value.
//  - flush=1: next state EMPTY, main and skid ctrl zeroed, occupancy 0; overrides in_fire and out_fire
//    in the same cycle (the incoming entry is dropped; the head entry is still seen downstream this cycle).
//  - rst has priority over flush; rst mid-operation drops all entries identically to flush plus data clear.
//  - in_valid may drop without in_ready (no upstream stability requirement); payload sampled only on in_fire.
// STRUCTURE
//  - Shared header pl_defs.vh: state encodings (PL_EMPTY=2'd0, PL_ONE=2'd1, PL_TWO=2'd2),
//    D|E payload widths (DE_DATA_W=204, DE_CTRL_W=12) and ctrl-field bit offsets.
//  - One sub-module: pl_slot (valid + ctrl + data register with load/clear), instantiated as main and skid;
//    skid instance generated only when SKID_EN=1.
//  - Control FSM and occupancy counter in this module; no other logic.
// TESTING
//  - Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0; in_ready=1 cycle after.
//  - Streaming: out_ready=1, push 0x1..0x8 back-to-back -> out_data 0x1..0x8 one cycle later, no gaps.
//  - Back-pressure: push A,B,C with out_ready=0 -> occupancy 1 then 2, in_ready=0 after B, C held upstream;
//    release out_ready -> A,B,C in order, occupancy 2->1->1->0.
//  - Flush: occupancy=2, flush=1 with in_valid=1 (D) -> next cycle out_valid=0, out_ctrl=0, D never emerges.
//  - Simultaneous: state ONE, in_fire & out_fire every cycle for 16 cycles -> occupancy stays 1, order kept.
//  - SKID_EN=0 build: out_ready=0 & out_valid=1 -> in_ready=0 same cycle; occupancy never exceeds 1.

Source files
------------

// File: rtl/pl_stage_hs_pkg.sv
// Shared definitions for the handshake pipeline-stage register: state encoding,
// D|E payload widths and control-field bit offsets.
package pl_stage_hs_pkg;

    localparam int DE_DATA_W = 204;
    localparam int DE_CTRL_W = 12;

    typedef enum logic [1:0] {
        PL_EMPTY = 2'd0,
        PL_ONE   = 2'd1,
        PL_TWO   = 2'd2
    } pl_state_e;

    // Control payload layout, LSB first.
    localparam int CTRL_RESULT_SRC_LSB  = 0;
    localparam int CTRL_RESULT_SRC_W    = 2;
    localparam int CTRL_ALU_CONTROL_LSB = 2;
    localparam int CTRL_ALU_CONTROL_W   = 4;
    localparam int CTRL_MEMWRITE_BIT    = 6;
    localparam int CTRL_ALU_SRC_BIT     = 7;
    localparam int CTRL_REGWRITE_BIT    = 8;
    localparam int CTRL_BRANCH_BIT      = 9;
    localparam int CTRL_JALR_BIT        = 10;
    localparam int CTRL_JUMP_BIT        = 11;

    function automatic logic [1:0] occ_of(input pl_state_e s);
        case (s)
            PL_ONE:  return 2'd1;
            PL_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pl_stage_hs_slot.sv
// One pipeline entry: valid flag, control payload and datapath payload.
// Clear kills the entry and zeroes control but keeps data; reset zeroes everything.
module pl_slot #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 204
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= ld_ctrl;
            data  <= ld_data;
        end
    end

endmodule

// File: rtl/pl_stage_hs.sv
// Pipeline-stage register with valid/ready handshake, flush and optional
// 2-entry skid buffer that makes in_ready a registered signal.
module pl_stage_hs
    import pl_stage_hs_pkg::*;
#(
    parameter int DATA_W  = DE_DATA_W,
    parameter int CTRL_W  = DE_CTRL_W,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pl_state_e         state;
    pl_state_e         state_next;
    logic              in_fire;
    logic              out_fire;
    logic              main_load;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    logic              main_valid;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_ld_ctrl;
    logic [DATA_W-1:0] main_ld_data;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // The skid is only ever valid in TWO, so it doubles as the refill-source select.
    assign main_ld_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    assign main_ld_data = skid_valid ? skid_data : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PL_EMPTY;
            occupancy <= 2'd0;
        end else begin
            state     <= state_next;
            occupancy <= occ_of(state_next);
        end
    end

    always_comb begin
        state_next = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
            state_next = PL_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                PL_EMPTY: begin
                    if (in_fire) begin
                        main_load  = 1'b1;
                        state_next = PL_ONE;
                    end
                end
                PL_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        main_clear = 1'b1;
                        state_next = PL_EMPTY;
                    end else if (in_fire && SKID_EN) begin
                        skid_load  = 1'b1;
                        state_next = PL_TWO;
                    end
                end
                PL_TWO: begin
                    if (out_fire) begin
                        main_load  = 1'b1;
                        skid_clear = 1'b1;
                        state_next = PL_ONE;
                    end
                end
                default: begin
                    state_next = PL_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    pl_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clear   (main_clear),
        .ld_ctrl (main_ld_ctrl),
        .ld_data (main_ld_data),
        .valid   (main_valid),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );

    assign out_valid = main_valid;

    generate
        if (SKID_EN) begin : g_skid
            pl_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load    (skid_load),
                .clear   (skid_clear),
                .ld_ctrl (in_ctrl),
                .ld_data (in_data),
                .valid   (skid_valid),
                .ctrl    (skid_ctrl),
                .data    (skid_data)
            );
            assign in_ready = (state != PL_TWO);
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;
            assign in_ready   = out_ready | ~out_valid;
        end
    endgenerate

endmodule

// File: tb/tb_pl_stage_hs.sv
// Randomized bench for pl_stage_hs: a FIFO-queue model of the stage, one skid
// build and one single-register build, both sharing clock and reset.
module tb_pl_stage_hs;

    localparam int DW = 204;
    localparam int CW = 12;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    logic          nsk_flush = 1'b0, nsk_in_valid = 1'b0, nsk_out_ready = 1'b0;
    logic [CW-1:0] nsk_in_ctrl = '0;
    logic [DW-1:0] nsk_in_data = '0;
    logic          nsk_in_ready, nsk_out_valid;
    logic [CW-1:0] nsk_out_ctrl;
    logic [DW-1:0] nsk_out_data;
    logic [1:0]    nsk_occupancy;

    entry_t        q[$];
    entry_t        q_nsk[$];
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] last_data_nsk = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pl_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
    );

    pl_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0)) dut_nsk (
        .clk(clk), .rst(rst), .flush(nsk_flush), .in_valid(nsk_in_valid), .in_ready(nsk_in_ready),
        .in_ctrl(nsk_in_ctrl), .in_data(nsk_in_data), .out_valid(nsk_out_valid), .out_ready(nsk_out_ready),
        .out_ctrl(nsk_out_ctrl), .out_data(nsk_out_data), .occupancy(nsk_occupancy)
    );

    function automatic entry_t rand_entry();
        entry_t        e;
        logic [223:0]  w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        e.ctrl = CW'($urandom);
        e.data = w[DW-1:0];
        return e;
    endfunction

    // Expected view of the skid build: a FIFO of capacity 2.
    function automatic logic exp_valid();
        return q.size() != 0;
    endfunction
    function automatic logic [CW-1:0] exp_ctrl();
        return (q.size() != 0) ? q[0].ctrl : '0;
    endfunction
    function automatic logic [DW-1:0] exp_data();
        return (q.size() != 0) ? q[0].data : last_data;
    endfunction
    function automatic logic exp_ready();
        return q.size() < 2;
    endfunction
    function automatic logic [1:0] exp_occ();
        return 2'(q.size());
    endfunction

    // Expected view of the single-register build: capacity 1, pass-through ready.
    function automatic logic exp_ready_nsk();
        return (q_nsk.size() == 0) || nsk_out_ready;
    endfunction

    task automatic drive(input bit rs, input bit v, input bit r, input bit f, input entry_t e);
        @(negedge clk);
        rst = rs;
        in_valid = v;
        out_ready = r;
        flush = f;
        in_ctrl = e.ctrl;
        in_data = e.data;
        #1;
    endtask

    task automatic drive_nsk(input bit v, input bit r, input bit f, input entry_t e);
        @(negedge clk);
        nsk_in_valid = v;
        nsk_out_ready = r;
        nsk_flush = f;
        nsk_in_ctrl = e.ctrl;
        nsk_in_data = e.data;
        #1;
    endtask

    // Advance one clock and apply the handshake rules to both queue models.
    task automatic tick(output bit acc);
        bit     inf, outf, inf_n, outf_n;
        entry_t e, e_n;
        inf    = in_valid && exp_ready();
        outf   = out_ready && exp_valid();
        inf_n  = nsk_in_valid && exp_ready_nsk();
        outf_n = nsk_out_ready && (q_nsk.size() != 0);
        e   = '{ctrl: in_ctrl, data: in_data};
        e_n = '{ctrl: nsk_in_ctrl, data: nsk_in_data};
        acc = inf;
        @(posedge clk);
        if (rst) begin
            q.delete();
            q_nsk.delete();
            last_data = '0;
            last_data_nsk = '0;
        end else begin
            if (flush) q.delete();
            else begin
                if (outf) void'(q.pop_front());
                if (inf) q.push_back(e);
            end
            if (nsk_flush) q_nsk.delete();
            else begin
                if (outf_n) void'(q_nsk.pop_front());
                if (inf_n) q_nsk.push_back(e_n);
            end
        end
        if (q.size() != 0) last_data = q[0].data;
        if (q_nsk.size() != 0) last_data_nsk = q_nsk[0].data;
    endtask

    task automatic test_reset();
        bit acc;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, rand_entry());
            tick(acc);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, rand_entry());
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_ctrl !== '0) begin bad++; $display("[TB] FAIL reset_ctrl got=%h exp=0", out_ctrl); end
        total++; if (out_data !== '0) begin bad++; $display("[TB] FAIL reset_data got=%h exp=0", out_data); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("[TB] FAIL reset_occ got=%0d exp=0", occupancy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (nsk_out_valid !== 1'b0 || nsk_occupancy !== 2'd0 || nsk_in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_nsk got valid=%b occ=%0d ready=%b exp 0/0/1",
                            nsk_out_valid, nsk_occupancy, nsk_in_ready);
        end
        tick(acc);
    endtask

    task automatic test_streaming();
        bit     acc;
        entry_t e;
        for (int k = 1; k <= 10; k++) begin
            e = rand_entry();
            e.data = DW'(k);
            drive(1'b0, k <= 8, 1'b1, 1'b0, e);
            if (k >= 2 && k <= 9) begin
                total++; if (out_valid !== 1'b1 || out_data !== DW'(k - 1)) begin
                    bad++; $display("[TB] FAIL stream_seq k=%0d got valid=%b data=%h exp data=%0d",
                                    k, out_valid, out_data, k - 1);
                end
            end
            total++; if (out_ctrl !== exp_ctrl() || occupancy !== exp_occ()) begin
                bad++; $display("[TB] FAIL stream_model k=%0d got ctrl=%h occ=%0d exp ctrl=%h occ=%0d",
                                k, out_ctrl, occupancy, exp_ctrl(), exp_occ());
            end
            tick(acc);
        end
    endtask

    task automatic test_backpressure();
        bit     acc;
        int     idx = 0;
        entry_t items[3];
        for (int i = 0; i < 3; i++) items[i] = rand_entry();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, idx < 3, 1'b0, 1'b0, items[idx < 3 ? idx : 2]);
            total++; if (occupancy !== exp_occ() || in_ready !== exp_ready() || out_data !== exp_data()) begin
                bad++; $display("[TB] FAIL bp_hold c=%0d got occ=%0d rdy=%b exp occ=%0d rdy=%b",
                                c, occupancy, in_ready, exp_occ(), exp_ready());
            end
            tick(acc);
            if (acc) idx++;
        end
        total++; if (idx != 2 || occupancy !== 2'd2) begin
            bad++; $display("[TB] FAIL bp_accepted got idx=%0d occ=%0d exp idx=2 occ=2", idx, occupancy);
        end
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, idx < 3, 1'b1, 1'b0, items[idx < 3 ? idx : 2]);
            total++; if (out_valid !== exp_valid() || out_ctrl !== exp_ctrl() || out_data !== exp_data()
                         || occupancy !== exp_occ() || in_ready !== exp_ready()) begin
                bad++; $display("[TB] FAIL bp_drain c=%0d got v=%b occ=%0d data=%h exp v=%b occ=%0d data=%h",
                                c, out_valid, occupancy, out_data, exp_valid(), exp_occ(), exp_data());
            end
            tick(acc);
            if (acc) idx++;
        end
    endtask

    task automatic test_flush();
        bit acc;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, rand_entry());
            tick(acc);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, rand_entry());
        total++; if (occupancy !== 2'd2) begin bad++; $display("[TB] FAIL flush_pre_occ got=%0d exp=2", occupancy); end
        tick(acc);
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, rand_entry());
            total++; if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0) begin
                bad++; $display("[TB] FAIL flush_empty c=%0d got v=%b ctrl=%h occ=%0d exp 0/0/0",
                                c, out_valid, out_ctrl, occupancy);
            end
            total++; if (out_data !== exp_data()) begin
                bad++; $display("[TB] FAIL flush_data_hold got=%h exp=%h", out_data, exp_data());
            end
            tick(acc);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        drive(1'b0, 1'b1, 1'b0, 1'b0, rand_entry());
        tick(acc);
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, rand_entry());
            total++; if (occupancy !== 2'd1 || out_valid !== 1'b1 || out_data !== exp_data()
                         || out_ctrl !== exp_ctrl()) begin
                bad++; $display("[TB] FAIL b2b c=%0d got occ=%0d data=%h exp occ=1 data=%h",
                                c, occupancy, out_data, exp_data());
            end
            tick(acc);
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, rand_entry());
            tick(acc);
        end
    endtask

    task automatic test_random();
        bit acc;
        for (int c = 0; c < 300; c++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0, rand_entry());
            if (!rst) begin
                total++; if (out_valid !== exp_valid() || out_ctrl !== exp_ctrl() || out_data !== exp_data()
                             || in_ready !== exp_ready() || occupancy !== exp_occ()) begin
                    bad++; $display("[TB] FAIL random c=%0d got v=%b r=%b occ=%0d ctrl=%h exp v=%b r=%b occ=%0d ctrl=%h",
                                    c, out_valid, in_ready, occupancy, out_ctrl,
                                    exp_valid(), exp_ready(), exp_occ(), exp_ctrl());
                end
            end
            tick(acc);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, rand_entry());
        tick(acc);
        drive(1'b0, 1'b0, 1'b1, 1'b0, rand_entry());
        tick(acc);
        drive(1'b0, 1'b0, 1'b0, 1'b0, rand_entry());
    endtask

    task automatic test_no_skid();
        bit acc;
        drive_nsk(1'b1, 1'b0, 1'b0, rand_entry());
        tick(acc);
        drive_nsk(1'b1, 1'b0, 1'b0, rand_entry());
        total++; if (nsk_in_ready !== 1'b0 || nsk_out_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL nsk_stall got ready=%b valid=%b exp ready=0 valid=1",
                            nsk_in_ready, nsk_out_valid);
        end
        nsk_out_ready = 1'b1;
        #1;
        total++; if (nsk_in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL nsk_pass_ready got=%b exp=1", nsk_in_ready);
        end
        tick(acc);
        for (int c = 0; c < 150; c++) begin
            drive_nsk($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                      rand_entry());
            total++; if (nsk_out_valid !== (q_nsk.size() != 0)
                         || nsk_out_ctrl !== ((q_nsk.size() != 0) ? q_nsk[0].ctrl : CW'(0))
                         || nsk_out_data !== ((q_nsk.size() != 0) ? q_nsk[0].data : last_data_nsk)
                         || nsk_in_ready !== exp_ready_nsk()
                         || nsk_occupancy !== 2'(q_nsk.size()) || nsk_occupancy > 2'd1) begin
                bad++; $display("[TB] FAIL nsk_random c=%0d got v=%b r=%b occ=%0d exp v=%b r=%b occ=%0d",
                                c, nsk_out_valid, nsk_in_ready, nsk_occupancy,
                                q_nsk.size() != 0, exp_ready_nsk(), q_nsk.size());
            end
            tick(acc);
        end
        drive_nsk(1'b0, 1'b0, 1'b0, rand_entry());
        tick(acc);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_random();
        test_no_skid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
